// File: rtl/alu_decode.sv
// alu_decode: registered MIPS instruction decode stage feeding the ALU.
// The combinational decode is captured into an output register (OR), with a
// one-entry skid register (SR) behind it so that in_ready can be a flop.
module alu_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  func_out,
  output logic        upper_out,
  output logic [31:0] imm_out,
  output logic        b_sel_imm,
  output logic        a_sel_shamt,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic        reg_write,
  output logic        illegal
);

  typedef struct packed {
    logic [5:0]  func;
    logic        upper;
    logic [31:0] imm;
    logic        bsel;
    logic        asel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        rw;
    logic        ill;
  } dec_t;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_ADDIU  = 6'd9;
  localparam logic [5:0] OP_SLTI   = 6'd10;
  localparam logic [5:0] OP_SLTIU  = 6'd11;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;

  dec_t        dec_s;
  dec_t        or_q, or_d, sr_q, sr_d;
  logic        or_valid_q, or_valid_d;
  logic        sr_valid_q, sr_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept_s, drain_s;
  logic [5:0]  op_s, funct_s;
  logic [31:0] simm_s, zimm_s;

  assign op_s    = in_instr[31:26];
  assign funct_s = in_instr[5:0];
  assign simm_s  = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zimm_s  = {16'h0000, in_instr[15:0]};

  // Decode the incoming instruction word into ALU controls.
  always_comb begin
    dec_s       = '0;
    dec_s.imm   = simm_s;
    dec_s.rs    = in_instr[25:21];
    dec_s.rt    = in_instr[20:16];
    dec_s.dest  = in_instr[15:11];
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin dec_s.func = funct_s; dec_s.rw = 1'b1; end
          6'h00: begin dec_s.func = 6'b110000; dec_s.asel = 1'b1; dec_s.rw = 1'b1; end
          6'h02: begin dec_s.func = 6'b110001; dec_s.asel = 1'b1; dec_s.rw = 1'b1; end
          6'h03: begin dec_s.func = 6'b110011; dec_s.asel = 1'b1; dec_s.rw = 1'b1; end
          6'h04: begin dec_s.func = 6'b110000; dec_s.rw = 1'b1; end
          6'h06: begin dec_s.func = 6'b110001; dec_s.rw = 1'b1; end
          6'h07: begin dec_s.func = 6'b110011; dec_s.rw = 1'b1; end
          6'h08: dec_s.func = 6'b111011;
          6'h09: begin dec_s.func = 6'b111011; dec_s.rw = 1'b1; end
          6'h19: dec_s.func = 6'b010000;
          6'h1B: dec_s.func = 6'b011000;
          default: dec_s.ill = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (in_instr[20:16])
          5'd0:    dec_s.func = 6'b111000;
          5'd1:    dec_s.func = 6'b111001;
          default: dec_s.ill = 1'b1;
        endcase
      end
      OP_J, OP_JAL: begin
        dec_s.func = 6'b111010;
        dec_s.imm  = {6'b000000, in_instr[25:0]};
        if (op_s == OP_JAL) begin
          dec_s.dest = 5'd31;
          dec_s.rw   = 1'b1;
        end else begin
          dec_s.rw   = 1'b0;
        end
      end
      OP_BEQ:  dec_s.func = 6'b111100;
      OP_BNE:  dec_s.func = 6'b111101;
      OP_BLEZ: dec_s.func = 6'b111110;
      OP_BGTZ: dec_s.func = 6'b111111;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        case (op_s)
          OP_ADDI:  dec_s.func = 6'b100000;
          OP_SLTI:  dec_s.func = 6'b101010;
          OP_SLTIU: dec_s.func = 6'b101011;
          default:  dec_s.func = 6'b100001;
        endcase
        dec_s.bsel = 1'b1;
        dec_s.dest = in_instr[20:16];
        dec_s.rw   = (op_s != OP_SW);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        case (op_s)
          OP_ANDI: dec_s.func = 6'b100100;
          OP_ORI:  dec_s.func = 6'b100101;
          OP_XORI: dec_s.func = 6'b100110;
          default: begin dec_s.func = 6'b100001; dec_s.upper = 1'b1; dec_s.rs = 5'd0; end
        endcase
        dec_s.imm  = zimm_s;
        dec_s.bsel = 1'b1;
        dec_s.dest = in_instr[20:16];
        dec_s.rw   = 1'b1;
      end
      default: dec_s.ill = 1'b1;
    endcase
    // Writes to $zero are never performed; illegal words never write.
    if (dec_s.ill || (dec_s.dest == 5'd0)) begin
      dec_s.rw = 1'b0;
    end else begin
      dec_s.rw = dec_s.rw;
    end
    if (dec_s.ill) begin
      dec_s.func = 6'b000000;
    end else begin
      dec_s.func = dec_s.func;
    end
  end

  // Flush drops any same-cycle accept; SR full implies in_ready is low.
  assign accept_s = in_valid && in_ready_q && !flush;
  assign drain_s  = or_valid_q && out_ready;

  // Next-state of the output and skid registers.
  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (!or_valid_q || drain_s) begin
      if (sr_valid_q) begin
        // in_ready was low, so no accept can coincide with this refill
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else if (accept_s) begin
        or_d       = dec_s;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        sr_d       = dec_s;
        sr_valid_d = 1'b1;
      end else begin
        sr_valid_d = sr_valid_q;
      end
    end
    in_ready_d = !sr_valid_d;
  end

  // State registers; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      or_q       <= '0;
      sr_q       <= '0;
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = or_valid_q;
  assign func_out    = or_q.func;
  assign upper_out   = or_q.upper;
  assign imm_out     = or_q.imm;
  assign b_sel_imm   = or_q.bsel;
  assign a_sel_shamt = or_q.asel;
  assign rs_out      = or_q.rs;
  assign rt_out      = or_q.rt;
  assign dest_out    = or_q.dest;
  assign reg_write   = or_q.rw;
  assign illegal     = or_q.ill;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed and randomized checks of the alu_decode stage.
module tb_alu_decode;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [5:0]  func_out;
  logic        upper_out, b_sel_imm, a_sel_shamt, reg_write, illegal;
  logic [31:0] imm_out;
  logic [4:0]  rs_out, rt_out, dest_out;
  logic [57:0] act_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [57:0] e; logic [57:0] m; } ent_t;

  int r_code[int];
  bit r_asel[int];
  bit r_nowr[int];
  int i_code[int];
  int br_code[int];
  int legal_ops[18]   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
  int legal_fn[20]    = '{0, 2, 3, 4, 6, 7, 8, 9, 25, 27, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};

  alu_decode dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .func_out(func_out), .upper_out(upper_out), .imm_out(imm_out),
    .b_sel_imm(b_sel_imm), .a_sel_shamt(a_sel_shamt),
    .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act_s = {illegal, reg_write, func_out, upper_out, b_sel_imm, a_sel_shamt,
                  rs_out, rt_out, dest_out, imm_out};

  task automatic init_tables();
    for (int f = 32; f <= 39; f++) r_code[f] = f;
    r_code[42] = 42; r_code[43] = 43;
    r_code[0] = 'h30; r_code[2] = 'h31; r_code[3] = 'h33;
    r_code[4] = 'h30; r_code[6] = 'h31; r_code[7] = 'h33;
    r_code[8] = 'h3b; r_code[9] = 'h3b; r_code[25] = 'h10; r_code[27] = 'h18;
    r_asel[0] = 1'b1; r_asel[2] = 1'b1; r_asel[3] = 1'b1;
    r_nowr[8] = 1'b1; r_nowr[25] = 1'b1; r_nowr[27] = 1'b1;
    i_code[8] = 'h20; i_code[9] = 'h21; i_code[10] = 'h2a; i_code[11] = 'h2b;
    i_code[12] = 'h24; i_code[13] = 'h25; i_code[14] = 'h26; i_code[15] = 'h21;
    i_code[35] = 'h21; i_code[43] = 'h21;
    br_code[4] = 'h3c; br_code[5] = 'h3d; br_code[6] = 'h3e; br_code[7] = 'h3f;
  endtask

  // Reference decode: table lookups by instruction class; mask marks fields that are defined.
  function automatic void model(input logic [31:0] ins, output logic [57:0] e, output logic [57:0] m);
    int op, fn;
    logic ill, rw, up, bs, as, dchk, ichk;
    logic [5:0] fc;
    logic [4:0] rs, rt, ds;
    logic [31:0] im, sx, zx;
    op = int'(ins[31:26]); fn = int'(ins[5:0]);
    rs = ins[25:21]; rt = ins[20:16]; ds = 5'd0;
    sx = {{16{ins[15]}}, ins[15:0]}; zx = {16'd0, ins[15:0]}; im = 32'd0;
    ill = 1'b0; rw = 1'b0; up = 1'b0; bs = 1'b0; as = 1'b0; fc = 6'd0; dchk = 1'b0; ichk = 1'b0;
    if (op == 0 && r_code.exists(fn)) begin
      fc = 6'(r_code[fn]); ds = ins[15:11]; dchk = 1'b1;
      rw = 1'(!r_nowr.exists(fn)); as = 1'(r_asel.exists(fn));
    end else if (i_code.exists(op)) begin
      fc = 6'(i_code[op]); ds = rt; dchk = 1'b1; bs = 1'b1; rw = 1'(op != 43);
      up = 1'(op == 15); if (op == 15) rs = 5'd0;
      im = (op >= 12 && op <= 15) ? zx : sx; ichk = 1'b1;
    end else if (br_code.exists(op)) begin
      fc = 6'(br_code[op]); im = sx; ichk = 1'b1;
    end else if (op == 1 && rt <= 5'd1) begin
      fc = (rt == 5'd0) ? 6'h38 : 6'h39; im = sx; ichk = 1'b1;
    end else if (op == 2 || op == 3) begin
      fc = 6'h3a; im = {6'd0, ins[25:0]}; ichk = 1'b1;
      if (op == 3) begin ds = 5'd31; dchk = 1'b1; rw = 1'b1; end
    end else begin
      ill = 1'b1;
    end
    if (ds == 5'd0) rw = 1'b0;
    e = {ill, rw, fc, up, bs, as, rs, rt, ds, im};
    m = {1'b1, 1'b1, 6'h3f, 1'b1, 1'b1, 1'b1, 5'h1f, 5'h1f,
         dchk ? 5'h1f : 5'h00, ichk ? 32'hffffffff : 32'h0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom();
    sel = $urandom_range(0, 9);
    if (sel < 4) begin
      w[31:26] = 6'(legal_ops[$urandom_range(0, 17)]);
      if (w[31:26] == 6'd1) w[20:16] = 5'($urandom_range(0, 2));
    end else if (sel < 8) begin
      w[31:26] = 6'd0;
      w[5:0] = 6'(legal_fn[$urandom_range(0, 19)]);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, in_ready, act_s} !== {1'b0, 1'b1, 58'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b data=%h, want v=0 r=1 data=0", out_valid, in_ready, act_s);
    end
  endtask

  // Present one instruction with out_ready high; outputs show it one cycle later.
  task automatic offer(input logic [31:0] ins);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_decode_itype();
    offer(32'h20080005);
    n_checks++;
    if ({out_valid, func_out, imm_out, b_sel_imm, dest_out, reg_write} !==
        {1'b1, 6'h20, 32'h5, 1'b1, 5'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL addi: got v=%b f=%h imm=%h b=%b d=%0d w=%b, want v=1 f=20 imm=5 b=1 d=8 w=1",
               out_valid, func_out, imm_out, b_sel_imm, dest_out, reg_write);
    end
    tick();
  endtask

  task automatic test_decode_lui_shift();
    offer(32'h3C091234);
    n_checks++;
    if ({out_valid, upper_out, func_out, imm_out, dest_out} !== {1'b1, 1'b1, 6'h21, 32'h1234, 5'd9}) begin
      n_fail++;
      $display("FAIL lui: got v=%b u=%b f=%h imm=%h d=%0d, want 1 1 21 1234 9",
               out_valid, upper_out, func_out, imm_out, dest_out);
    end
    offer(32'h00095100);
    n_checks++;
    if ({out_valid, func_out, a_sel_shamt, rt_out, dest_out} !== {1'b1, 6'h30, 1'b1, 5'd9, 5'd10}) begin
      n_fail++;
      $display("FAIL sll: got v=%b f=%h a=%b rt=%0d d=%0d, want 1 30 1 9 10",
               out_valid, func_out, a_sel_shamt, rt_out, dest_out);
    end
    tick();
  endtask

  task automatic test_decode_branch_illegal();
    offer(32'h1109FFFE);
    n_checks++;
    if ({out_valid, func_out, imm_out, reg_write} !== {1'b1, 6'h3c, 32'hFFFFFFFE, 1'b0}) begin
      n_fail++;
      $display("FAIL beq: got v=%b f=%h imm=%h w=%b, want 1 3c fffffffe 0",
               out_valid, func_out, imm_out, reg_write);
    end
    offer(32'hFC000000);
    n_checks++;
    if ({out_valid, illegal, func_out, reg_write} !== {1'b1, 1'b1, 6'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal: got v=%b i=%b f=%h w=%b, want 1 1 00 0",
               out_valid, illegal, func_out, reg_write);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] prog [3];
    logic [4:0]  dst [3];
    int idx;
    prog[0] = 32'h20080005; prog[1] = 32'h3C091234; prog[2] = 32'h00095100;
    dst[0] = 5'd8; dst[1] = 5'd9; dst[2] = 5'd10;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3); in_instr = (idx < 3) ? prog[idx] : 32'd0;
      if (c >= 2) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready cycle %0d: got %b want 0", c, in_ready);
        end
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    n_checks++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL stall_accepts: got %0d want 2", idx);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = (idx < 3); in_instr = (idx < 3) ? prog[idx] : 32'd0;
      n_checks++;
      if ({out_valid, dest_out} !== {1'b1, dst[c]}) begin
        n_fail++;
        $display("FAIL drain_order slot %0d: got v=%b d=%0d want v=1 d=%0d", c, out_valid, dest_out, dst[c]);
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if ({idx == 3, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_end: got accepts=%0d v=%b want accepts=3 v=0", idx, out_valid);
    end
  endtask

  task automatic test_flush(input int fill);
    out_ready = 1'b0;
    for (int c = 0; c < fill; c++) begin
      in_valid = 1'b1; in_instr = 32'h20080005 + 32'(c);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h3C0A5555;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_fill%0d: got v=%b r=%b want v=0 r=1", fill, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_dropped_fill%0d: got v=%b d=%0d want v=0", fill, out_valid, dest_out);
      end
      tick();
    end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_instr = 32'h3C091234;
      tick();
    end
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, act_s} !== {1'b0, 1'b1, 58'd0}) begin
      n_fail++;
      $display("FAIL midstream_reset: got v=%b r=%b data=%h want v=0 r=1 data=0", out_valid, in_ready, act_s);
    end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t ent;
    logic exp_v, exp_r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      n_checks++;
      if ({out_valid, in_ready} !== {exp_v, exp_r}) begin
        n_fail++;
        $display("FAIL random_hs cycle %0d: got v=%b r=%b want v=%b r=%b", c, out_valid, in_ready, exp_v, exp_r);
      end
      if (exp_v) begin
        n_checks++;
        if ((act_s & q[0].m) !== (q[0].e & q[0].m)) begin
          n_fail++;
          $display("FAIL random_data cycle %0d: got %h want %h mask %h", c, act_s, q[0].e, q[0].m);
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_r) begin
          model(in_instr, ent.e, ent.m);
          q.push_back(ent);
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    init_tables();
    test_reset();
    test_decode_itype();
    test_decode_lui_shift();
    test_decode_branch_illegal();
    test_backpressure();
    do_reset();
    test_flush(2);
    test_flush(1);
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
